// File: rtl/adder_pkg.sv
// Shared definitions for the adder32 area: controller state encoding and default width.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/fadder.sv
// 1-bit full-adder cell, shared across all bit positions by the serial adder.
module fadder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell walks the operands LSB first, one bit per clock,
// with valid/ready handshakes on the operand and result sides.
module serial_adder_ctrl
   import adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [CNT_W-1:0] bit_cnt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;
   logic             cell_s;
   logic             cell_co;
   logic [WIDTH-1:0] sum_next;

   fadder u_fadder (
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .ci (carry),
      .s  (cell_s),
      .co (cell_co)
   );

   // New sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
   generate
      if (WIDTH == 1) begin : g_sum_one
         assign sum_next = cell_s;
      end else begin : g_sum_wide
         assign sum_next = {cell_s, sum[WIDTH-1:1]};
      end
   endgenerate

   assign in_ready = (state == IDLE) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         busy      <= 1'b0;
         bit_cnt   <= '0;
         carry     <= 1'b0;
         a_sh      <= '0;
         b_sh      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh    <= a;
                  b_sh    <= b;
                  carry   <= cin;
                  bit_cnt <= '0;
                  busy    <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               sum     <= sum_next;
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               carry   <= cell_co;
               bit_cnt <= bit_cnt + CNT_W'(1);
               if (bit_cnt == LAST_CNT) begin
                  cout      <= cell_co;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               // Result is held until taken; in_ready only returns on the following cycle.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
